regfile_wb_driver: RTL

//  MEM/WB pipeline register and write-port driver for Regfile; produces clk-aligned RegWr/Rw/Busw.

---
 rtl/regfile_wb_driver_if.sv | 43 ++++
 rtl/regfile_wb_driver.sv | 83 ++++++++
 2 files changed

// File: rtl/regfile_wb_driver_if.sv
// Bundle between the MEM/WB pipeline control, the Regfile write port and the EX-stage forwarding compare.
// The slave modport is the WB driver; the master modport is whoever feeds MEM results and consumes the write port.
interface regfile_wb_driver_if #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int CW = 32
);
    logic          mem_valid;
    logic          mem_RegWr;
    logic          mem_RegDst;
    logic          mem_MemtoReg;
    logic          mem_Overflow;
    logic [AW-1:0] mem_Rt;
    logic [AW-1:0] mem_Rd;
    logic [DW-1:0] mem_AluOut;
    logic [DW-1:0] mem_MemData;
    logic          wb_stall;
    logic          wb_flush;
    logic [AW-1:0] q_Ra;
    logic [AW-1:0] q_Rb;
    logic          RegWr;
    logic [AW-1:0] Rw;
    logic [DW-1:0] Busw;
    logic          fwd_A;
    logic          fwd_B;
    logic [DW-1:0] fwd_data;
    logic [CW-1:0] retire_cnt;
    logic [CW-1:0] ovf_cnt;

    modport slave (
        input  mem_valid, mem_RegWr, mem_RegDst, mem_MemtoReg, mem_Overflow,
        input  mem_Rt, mem_Rd, mem_AluOut, mem_MemData,
        input  wb_stall, wb_flush, q_Ra, q_Rb,
        output RegWr, Rw, Busw, fwd_A, fwd_B, fwd_data, retire_cnt, ovf_cnt
    );

    modport master (
        output mem_valid, mem_RegWr, mem_RegDst, mem_MemtoReg, mem_Overflow,
        output mem_Rt, mem_Rd, mem_AluOut, mem_MemData,
        output wb_stall, wb_flush, q_Ra, q_Rb,
        input  RegWr, Rw, Busw, fwd_A, fwd_B, fwd_data, retire_cnt, ovf_cnt
    );
endinterface

// File: rtl/regfile_wb_driver.sv
// MEM/WB stage register and Regfile write-port driver with WB->EX forwarding compare
// and per-instruction retire/overflow counters.
module regfile_wb_driver #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int CW = 32
) (
    input logic               clk,
    input logic               rst,
    regfile_wb_driver_if.slave bus
);
    logic          wb_valid;
    logic          done;
    logic          wb_RegWr;
    logic          wb_RegDst;
    logic          wb_MemtoReg;
    logic          wb_Overflow;
    logic [AW-1:0] wb_Rt;
    logic [AW-1:0] wb_Rd;
    logic [DW-1:0] wb_AluOut;
    logic [DW-1:0] wb_MemData;
    logic [CW-1:0] retire_q;
    logic [CW-1:0] ovf_q;

    logic [AW-1:0] rw;
    logic [DW-1:0] busw;
    logic          intent;

    assign rw     = wb_RegDst ? wb_Rd : wb_Rt;
    assign busw   = wb_MemtoReg ? wb_MemData : wb_AluOut;
    assign intent = wb_valid & wb_RegWr & ~wb_Overflow & (rw != '0);

    // done only gates the write strobe; forwarding keeps using intent while the instruction is held
    assign bus.RegWr      = intent & ~done;
    assign bus.Rw         = rw;
    assign bus.Busw       = busw;
    assign bus.fwd_A      = intent & (bus.q_Ra == rw);
    assign bus.fwd_B      = intent & (bus.q_Rb == rw);
    assign bus.fwd_data   = busw;
    assign bus.retire_cnt = retire_q;
    assign bus.ovf_cnt    = ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid    <= 1'b0;
            done        <= 1'b0;
            wb_RegWr    <= 1'b0;
            wb_RegDst   <= 1'b0;
            wb_MemtoReg <= 1'b0;
            wb_Overflow <= 1'b0;
            wb_Rt       <= '0;
            wb_Rd       <= '0;
            wb_AluOut   <= '0;
            wb_MemData  <= '0;
            retire_q    <= '0;
            ovf_q       <= '0;
        end else begin
            // Count on the first WB cycle only, so a stalled instruction is counted once
            if (wb_valid && !done) begin
                if (wb_Overflow) ovf_q    <= ovf_q + 1'b1;
                else             retire_q <= retire_q + 1'b1;
            end

            if (bus.wb_stall) begin
                if (wb_valid) done <= 1'b1;
            end else if (bus.wb_flush) begin
                wb_valid <= 1'b0;
                done     <= 1'b0;
            end else begin
                wb_valid    <= bus.mem_valid;
                done        <= 1'b0;
                wb_RegWr    <= bus.mem_RegWr;
                wb_RegDst   <= bus.mem_RegDst;
                wb_MemtoReg <= bus.mem_MemtoReg;
                wb_Overflow <= bus.mem_Overflow;
                wb_Rt       <= bus.mem_Rt;
                wb_Rd       <= bus.mem_Rd;
                wb_AluOut   <= bus.mem_AluOut;
                wb_MemData  <= bus.mem_MemData;
            end
        end
    end
endmodule
